// File: rtl/rst_sequencer.sv
// Power-up / reset sequencer: pulses the PLL reset, waits for lock, debounces the
// reset key and holds the Qsys system in reset for a fixed interval before release.
module rst_sequencer #(
  parameter int PLL_ARESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT      = 500000,
  parameter int HOLD_CYCLES       = 1024,
  parameter int DEBOUNCE_CYCLES   = 1000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_rst_n,
  input  logic       pll_locked,
  output logic       pll_areset,
  output logic       qsys_rst_n,
  output logic       rst_done,
  output logic [7:0] retry_cnt
);

  localparam int MAX_AT  = (PLL_ARESET_CYCLES > LOCK_TIMEOUT) ? PLL_ARESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_AT > HOLD_CYCLES) ? MAX_AT : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] ARESET_LAST  = CNT_W'(PLL_ARESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    KEY       = 3'd3,
    RUN       = 3'd4
  } state_t;

  logic [1:0]       lock_sync_q, lock_sync_d;
  logic [1:0]       key_sync_q, key_sync_d;
  logic             key_stable_q, key_stable_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             pll_areset_q, pll_areset_d;
  logic             qsys_rst_n_q, qsys_rst_n_d;
  logic             rst_done_q, rst_done_d;

  logic locked_s;
  logic key_s;
  logic key_pressed;
  logic lock_fail;

  assign locked_s    = lock_sync_q[1];
  assign key_s       = key_sync_q[1];
  assign key_pressed = !key_stable_q;

  always_comb begin
    lock_sync_d  = {lock_sync_q[0], pll_locked};
    key_sync_d   = {key_sync_q[0], key_rst_n};

    // A change is accepted only after it has persisted for DEBOUNCE_CYCLES samples.
    key_stable_d = key_stable_q;
    db_cnt_d     = '0;
    if (key_s != key_stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_stable_d = key_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    state_d   = state_q;
    lock_fail = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == ARESET_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = HOLD;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = PLL_RST;
          lock_fail = 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s) begin
          state_d   = PLL_RST;
          lock_fail = 1'b1;
        end else if (key_pressed) begin
          state_d = KEY;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      KEY: begin
        if (!locked_s) begin
          state_d   = PLL_RST;
          lock_fail = 1'b1;
        end else if (!key_pressed) begin
          state_d = HOLD;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d   = PLL_RST;
          lock_fail = 1'b1;
        end else if (key_pressed) begin
          state_d = KEY;
        end
      end
      default: state_d = PLL_RST;
    endcase

    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;

    retry_d = retry_q;
    if (lock_fail && (retry_q != 8'hFF)) retry_d = retry_q + 8'd1;

    // Outputs decode the next state so they change on the same edge as the state.
    pll_areset_d = (state_d == PLL_RST);
    qsys_rst_n_d = (state_d == RUN);
    rst_done_d   = (state_d == RUN);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lock_sync_q  <= 2'b00;
      key_sync_q   <= 2'b11;
      key_stable_q <= 1'b1;
      db_cnt_q     <= '0;
      state_q      <= PLL_RST;
      cnt_q        <= '0;
      retry_q      <= 8'd0;
      pll_areset_q <= 1'b1;
      qsys_rst_n_q <= 1'b0;
      rst_done_q   <= 1'b0;
    end else begin
      lock_sync_q  <= lock_sync_d;
      key_sync_q   <= key_sync_d;
      key_stable_q <= key_stable_d;
      db_cnt_q     <= db_cnt_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_areset_q <= pll_areset_d;
      qsys_rst_n_q <= qsys_rst_n_d;
      rst_done_q   <= rst_done_d;
    end
  end

  assign pll_areset = pll_areset_q;
  assign qsys_rst_n = qsys_rst_n_q;
  assign rst_done   = rst_done_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: a cycle-level reference model predicts the
// outputs after every clock edge, a separate monitor compares them against the DUT.
module tb_rst_sequencer;

  localparam int PA = 4;
  localparam int LT = 64;
  localparam int HC = 16;
  localparam int DB = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_rst_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_areset;
  logic       qsys_rst_n;
  logic       rst_done;
  logic [7:0] retry_cnt;

  rst_sequencer #(
    .PLL_ARESET_CYCLES(PA),
    .LOCK_TIMEOUT     (LT),
    .HOLD_CYCLES      (HC),
    .DEBOUNCE_CYCLES  (DB)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_rst_n (key_rst_n),
    .pll_locked(pll_locked),
    .pll_areset(pll_areset),
    .qsys_rst_n(qsys_rst_n),
    .rst_done  (rst_done),
    .retry_cnt (retry_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic       areset;
    logic       qn;
    logic       done;
    logic [7:0] retry;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phases with entry timestamps, inputs seen through 2-edge delay lines.
  localparam int M_PLL  = 0;
  localparam int M_WAIT = 1;
  localparam int M_HOLD = 2;
  localparam int M_KEY  = 3;
  localparam int M_RUN  = 4;

  int         m_edge = 0;
  int         m_phase = M_PLL;
  int         m_entry = 0;
  logic [7:0] m_retry = 8'd0;
  bit         m_stable = 1'b1;
  int         m_run = 0;
  bit         lk_line[$];
  bit         key_line[$];

  function automatic void model_reset();
    m_phase  = M_PLL;
    m_entry  = m_edge;
    m_retry  = 8'd0;
    m_stable = 1'b1;
    m_run    = 0;
    lk_line  = {1'b0, 1'b0};
    key_line = {1'b1, 1'b1};
  endfunction

  function automatic void lock_lost();
    m_phase = M_PLL;
    if (m_retry != 8'd255) m_retry = m_retry + 8'd1;
  endfunction

  function automatic void model_edge(input bit rst, input bit lk, input bit key);
    bit locked;
    bit ksync;
    bit pressed;
    int dwell;
    int prev;
    m_edge++;
    if (rst) begin
      model_reset();
    end else begin
      locked  = lk_line[0];
      ksync   = key_line[0];
      pressed = !m_stable;
      dwell   = m_edge - m_entry;
      prev    = m_phase;
      if (m_phase == M_PLL) begin
        if (dwell == PA) m_phase = M_WAIT;
      end else if (m_phase == M_WAIT) begin
        if (locked) m_phase = M_HOLD;
        else if (dwell == LT) lock_lost();
      end else if (!locked) begin
        lock_lost();
      end else if (m_phase == M_HOLD) begin
        if (pressed) m_phase = M_KEY;
        else if (dwell == HC) m_phase = M_RUN;
      end else if (m_phase == M_KEY) begin
        if (!pressed) m_phase = M_HOLD;
      end else begin
        if (pressed) m_phase = M_KEY;
      end
      if (m_phase != prev) m_entry = m_edge;
      if (ksync != m_stable) begin
        m_run++;
        if (m_run == DB) begin
          m_stable = ksync;
          m_run    = 0;
        end
      end else begin
        m_run = 0;
      end
      void'(lk_line.pop_front());
      lk_line.push_back(lk);
      void'(key_line.pop_front());
      key_line.push_back(key);
    end
    exp_q.push_back({m_phase == M_PLL, m_phase == M_RUN, m_phase == M_RUN, m_retry});
  endfunction

  task automatic step(input bit rst, input bit lk, input bit key);
    @(negedge sys_clk);
    sys_rst    = rst;
    pll_locked = lk;
    key_rst_n  = key;
    model_edge(rst, lk, key);
  endtask

  task automatic steps(input int n, input bit lk, input bit key);
    repeat (n) step(1'b0, lk, key);
  endtask

  // Monitor: one expected word per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {pll_areset, qsys_rst_n, rst_done, retry_cnt};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL edge_outputs t=%0t got areset=%b qsys_rst_n=%b rst_done=%b retry=%0d, expected areset=%b qsys_rst_n=%b rst_done=%b retry=%0d",
                   $time, a.areset, a.qn, a.done, a.retry, e.areset, e.qn, e.done, e.retry);
        end
      end
    end
  end

  initial begin
    bit r_lk;
    bit r_key;
    int r_len;
    model_reset();

    $display("scenario 1: power-up, lock 10 cycles after release");
    repeat (3) step(1'b1, 1'b0, 1'b1);
    steps(10, 1'b0, 1'b1);
    steps(40, 1'b1, 1'b1);

    $display("scenario 3: one-cycle lock loss in RUN, then relock");
    steps(1, 1'b0, 1'b1);
    steps(60, 1'b1, 1'b1);

    $display("scenario 4: key bounce, then long press and release");
    repeat (3) begin
      steps(5, 1'b1, 1'b0);
      steps(3, 1'b1, 1'b1);
    end
    steps(20, 1'b1, 1'b1);
    steps(20, 1'b1, 1'b0);
    steps(45, 1'b1, 1'b1);

    $display("scenario 5: lock lost while key held");
    steps(20, 1'b1, 1'b0);
    steps(1, 1'b0, 1'b0);
    steps(40, 1'b1, 1'b0);
    steps(45, 1'b1, 1'b1);

    $display("scenario random: 80 random lock/key runs");
    for (int i = 0; i < 80; i++) begin
      r_lk  = ($urandom_range(0, 3) != 0);
      r_key = ($urandom_range(0, 4) != 0);
      r_len = $urandom_range(1, 40);
      steps(r_len, r_lk, r_key);
    end
    steps(120, 1'b1, 1'b1);

    $display("scenario 6: asynchronous reset mid-HOLD");
    repeat (3) step(1'b1, 1'b1, 1'b1);
    steps(12, 1'b1, 1'b1);
    steps(60, 1'b0, 1'b1);
    steps(12, 1'b1, 1'b1);
    @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    n_checks++;
    if ({pll_areset, qsys_rst_n, rst_done, retry_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL async_reset got areset=%b qsys_rst_n=%b rst_done=%b retry=%0d, expected 1 0 0 0",
               pll_areset, qsys_rst_n, rst_done, retry_cnt);
    end
    repeat (2) step(1'b1, 1'b1, 1'b1);
    steps(40, 1'b1, 1'b1);

    $display("scenario 2: 300 lock timeouts, retry_cnt saturates");
    steps(300 * (PA + LT) + 10, 1'b0, 1'b1);
    steps(40, 1'b1, 1'b1);

    @(posedge sys_clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
